// File: rtl/feynman_pkg.sv
// Purpose : shared constants and types for the Feynman (CNOT) stream decoder.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package feynman_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  // Occupancy of the 2-entry elastic buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  // Decoded operand pair at the default word width.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } pair_t;

endpackage

// File: rtl/feynman_dec_fifo2.sv
// Purpose : 2-entry in-order FIFO holding decoded (a, b) pairs.
// Latency : a push into an empty FIFO is visible at the head one edge later.
// Backpressure: full/empty come from registered occupancy only. A push while
//               full and a pop while empty are ignored.
// Ports   : clk, rst (sync, active-high); push/din_a/din_b write side;
//           pop/dout_a/dout_b read side (head entry); full, empty status.
module feynman_dec_fifo2
  import feynman_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic             pop,
  output logic [WIDTH-1:0] dout_a,
  output logic [WIDTH-1:0] dout_b,
  output logic             full,
  output logic             empty
);

  occ_t             state;
  logic [WIDTH-1:0] head_a, head_b;
  logic [WIDTH-1:0] tail_a, tail_b;
  logic             push_ok, pop_ok;

  assign full    = (state == FULL);
  assign empty   = (state == EMPTY);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout_a  = head_a;
  assign dout_b  = head_b;

  // The head register always feeds the outputs. The tail holds the second
  // word only while FULL and shifts into the head on the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      head_a <= '0;
      head_b <= '0;
      tail_a <= '0;
      tail_b <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push_ok) begin
            head_a <= din_a;
            head_b <= din_b;
            state  <= ONE;
          end
        end
        ONE: begin
          if (push_ok && pop_ok) begin
            // The old head leaves, and the new word replaces it directly.
            head_a <= din_a;
            head_b <= din_b;
          end else if (push_ok) begin
            tail_a <= din_a;
            tail_b <= din_b;
            state  <= FULL;
          end else if (pop_ok) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop_ok) begin
            head_a <= tail_a;
            head_b <= tail_b;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/feynman_stream_decoder.sv
// Purpose : recovers A = P and B = P ^ Q from Feynman-encoded pairs, buffers
//           them in a 2-deep elastic FIFO and counts delivered words.
// Latency : one cycle from input handshake to out_valid when the FIFO is empty;
//           sustains one pair per cycle.
// Backpressure: in_ready drops only when both entries are held. It depends on
//               registered state alone, so out_ready has no combinational path
//               to in_ready.
// Ports   : clk, rst (sync, active-high); in_valid/in_ready/in_p/in_q input
//           stream; out_valid/out_ready/out_a/out_b output stream; word_count.
//           Optional macro FEYNMAN_DEC_PARITY_EN adds in_par (even parity over
//           {in_p, in_q}) and the sticky par_err flag.
module feynman_stream_decoder
  import feynman_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_q,
`ifdef FEYNMAN_DEC_PARITY_EN
  input  logic             in_par,
  output logic             par_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [CNT_W-1:0] word_count
);

  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] dec_a, dec_b;

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The pair is decoded before storage so the FIFO holds operands directly.
  assign dec_a = in_p;
  assign dec_b = in_p ^ in_q;

  feynman_dec_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din_a (dec_a),
    .din_b (dec_b),
    .pop   (pop),
    .dout_a(out_a),
    .dout_b(out_b),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The count wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= '0;
    end else if (pop) begin
      word_count <= word_count + CNT_W'(1);
    end
  end

`ifdef FEYNMAN_DEC_PARITY_EN
  // Even parity: the XOR of P, Q and the parity bit must be zero. The word is
  // forwarded unchanged, and only the flag records the error.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (push && (^{in_p, in_q, in_par})) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_feynman_stream_decoder.sv
module tb_feynman_stream_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_p, in_q;
  logic       in_par;
  logic       out_ready;

  logic       in_ready, out_valid;
  logic [7:0] out_a, out_b;
  logic [15:0] word_count;
  logic       par_err;

  logic       in_ready4, out_valid4;
  logic [7:0] out_a4, out_b4;
  logic [3:0] word_count4;
  logic       par_err4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_a [100];
  logic [7:0] exp_b [100];

  always #5 clk = ~clk;

  feynman_stream_decoder #(.WIDTH(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_q      (in_q),
`ifdef FEYNMAN_DEC_PARITY_EN
    .in_par    (in_par),
    .par_err   (par_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .word_count(word_count)
  );

  feynman_stream_decoder #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in_p      (in_p),
    .in_q      (in_q),
`ifdef FEYNMAN_DEC_PARITY_EN
    .in_par    (in_par),
    .par_err   (par_err4),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_a     (out_a4),
    .out_b     (out_b4),
    .word_count(word_count4)
  );

`ifndef FEYNMAN_DEC_PARITY_EN
  assign par_err  = 1'b0;
  assign par_err4 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; afterwards outputs are settled and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a pair with correct even parity.
  task automatic drive(input logic v, input logic [7:0] p, input logic [7:0] q);
    in_valid = v;
    in_p     = p;
    in_q     = q;
    in_par   = ^{p, q};
  endtask

  initial begin
    logic [7:0] rp, rq;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    step();
    step();
    rst = 1'b0;

    // Fill to FULL, then reset mid-stream.
    drive(1'b1, 8'h11, 8'h22);
    step();
    drive(1'b1, 8'h33, 8'h44);
    step();
    drive(1'b0, 8'h00, 8'h00);
    check("full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_a",      32'(out_a),      32'h00);
    check("rst_out_b",      32'(out_b),      32'h00);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_par_err",    32'(par_err),    32'd0);

    // Single word.
    out_ready = 1'b1;
    drive(1'b1, 8'hA5, 8'h0F);
    step();
    drive(1'b0, 8'h00, 8'h00);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_a",     32'(out_a),     32'hA5);
    check("single_b",     32'(out_b),     32'hAA);
    step();
    check("single_count", 32'(word_count), 32'd1);
    check("single_empty", 32'(out_valid),  32'd0);

    // Back-pressure.
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h03);
    step();
    drive(1'b1, 8'h02, 8'h02);
    step();
    drive(1'b1, 8'h04, 8'h00);
    check("bp_in_ready_full", 32'(in_ready),  32'd0);
    check("bp_head_a",        32'(out_a),     32'h01);
    check("bp_head_b",        32'(out_b),     32'h02);
    step();
    check("bp_hold_b",        32'(out_b),     32'h02);
    check("bp_hold_in_ready", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    step();
    check("bp_second_b",      32'(out_b),     32'h00);
    check("bp_second_a",      32'(out_a),     32'h02);
    check("bp_ready_back",    32'(in_ready),  32'd1);
    step();
    drive(1'b0, 8'h00, 8'h00);
    check("bp_third_b",       32'(out_b),     32'h04);
    check("bp_third_a",       32'(out_a),     32'h04);
    step();
    check("bp_drained",       32'(out_valid), 32'd0);
    check("bp_count",         32'(word_count), 32'd4);

    // Streaming: 100 back-to-back pairs, one output per cycle.
    for (int i = 0; i <= 100; i++) begin
      if (i < 100) begin
        rp = 8'($urandom);
        rq = 8'($urandom);
        exp_a[i] = rp;
        exp_b[i] = rp ^ rq;
        drive(1'b1, rp, rq);
        check("stream_in_ready", 32'(in_ready), 32'd1);
      end else begin
        drive(1'b0, 8'h00, 8'h00);
      end
      step();
      if (i < 100) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_a",     32'(out_a),     32'(exp_a[i]));
        check("stream_b",     32'(out_b),     32'(exp_b[i]));
      end else begin
        check("stream_drained", 32'(out_valid), 32'd0);
      end
    end
    check("stream_count",  32'(word_count),  32'd104);
    check("stream_count4", 32'(word_count4), 32'd8);

    // Counter wrap on the 4-bit instance: 17 handshakes leave 1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("wrap_rst_count4", 32'(word_count4), 32'd0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i), 8'h5A);
      step();
    end
    drive(1'b0, 8'h00, 8'h00);
    step();
    check("wrap_count4", 32'(word_count4), 32'd1);
    check("wrap_count",  32'(word_count),  32'd17);
    check("wrap_b4",     32'(out_b4),      32'(8'd16 ^ 8'h5A));

`ifdef FEYNMAN_DEC_PARITY_EN
    // Bad parity on one word: flag sets and sticks, data still delivered.
    check("par_clear", 32'(par_err), 32'd0);
    in_valid = 1'b1;
    in_p     = 8'h01;
    in_q     = 8'h00;
    in_par   = 1'b0;
    step();
    check("par_set",   32'(par_err), 32'd1);
    check("par_a",     32'(out_a),   32'h01);
    check("par_b",     32'(out_b),   32'h01);
    drive(1'b1, 8'h03, 8'h00);
    step();
    drive(1'b0, 8'h00, 8'h00);
    check("par_sticky",  32'(par_err), 32'd1);
    check("par_good_b",  32'(out_b),   32'h03);
    step();
    check("par_sticky2", 32'(par_err), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("par_rst",     32'(par_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/feynman_stream_decoder.md
# feynman_stream_decoder

Streaming inverse of the two-output Feynman (CNOT) encoding used in the TCAM datapath: accepts encoded word pairs P = A and Q = A ^ B over a valid/ready handshake and recovers the original operands A and B. Sits at the receive end of any link that carries Feynman-encoded key/mask words, ahead of the TCAM compare logic. Contains a 2-entry elastic buffer so back-pressure never drops or duplicates a word. Keeps a running count of delivered words.

## Interface
- WIDTH, 8, bit width of each of the P/Q/A/B words (≥1)
- CNT_W, 16, width of the delivered-word counter (≥1)

- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  encoded pair present on in_p/in_q
- in_ready  output  1  block can accept a pair this cycle
- in_p  input  WIDTH  encoded P word (= A)
- in_q  input  WIDTH  encoded Q word (= A ^ B)
- in_par  input  1  even parity over {in_p, in_q}; present only with FEYNMAN_DEC_PARITY_EN
- out_valid  output  1  decoded pair present on out_a/out_b
- out_ready  input  1  downstream accepts the decoded pair
- out_a  output  WIDTH  decoded A = P
- out_b  output  WIDTH  decoded B = P ^ Q
- word_count  output  CNT_W  number of output handshakes since reset, modulo 2^CNT_W
- par_err  output  1  sticky parity-error flag; present only with FEYNMAN_DEC_PARITY_EN

## Operation
- Input handshake: pair accepted on a rising edge where in_valid && in_ready. Output handshake: pair consumed on a rising edge where out_valid && out_ready.
- Decode done before storage: entry stores A = in_p, B = in_p ^ in_q. No arithmetic, pure bitwise, WIDTH-for-WIDTH.
- Storage: 2-entry FIFO, strict in-order. Occupancy states EMPTY (0), ONE (1), FULL (2):
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push+pop same edge → ONE (new word becomes head).
  - FULL: pop → ONE; push impossible (in_ready = 0).
- in_ready = (state != FULL), derived from registered state only; no combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY); out_a/out_b = head entry, stable while out_valid && !out_ready.
- word_count increments by 1 on each output handshake; wraps from 2^CNT_W−1 to 0.
- Reset (any cycle, including mid-transfer): state → EMPTY, stored entries discarded, word_count = 0, par_err = 0. Outputs after reset: in_ready = 1, out_valid = 0, out_a = 0, out_b = 0, word_count = 0.
- in_p/in_q/in_par are ignored when in_valid = 0 or in_ready = 0.

## Timing
- Latency: pair accepted at edge N appears on out_a/out_b with out_valid = 1 after edge N (visible in cycle N+1) when the FIFO was EMPTY.
- Throughput: one pair per cycle sustained while out_ready = 1.
- Back-pressure: with out_ready held 0, exactly two pairs are accepted, then in_ready = 0 until the first pop; in_ready returns to 1 in the cycle after that pop edge.
- word_count and par_err update on the same edge as the triggering handshake.

## Configuration
- FEYNMAN_DEC_PARITY_EN defined: in_par and par_err ports exist. On each accepted pair, if ^{in_p, in_q, in_par} != 0, par_err sets on that edge and stays 1 until rst. Word is still decoded and forwarded unchanged.
- Not defined: in_par and par_err ports absent, no parity logic; all other behaviour identical.

## Structure
- Shared package feynman_pkg: default WIDTH, CNT_W constants; occupancy state enum (EMPTY, ONE, FULL); decoded-pair struct {a, b}.
- One sub-module: feynman_dec_fifo2 (2-entry FIFO with occupancy state, push/pop, full/empty); the top holds the XOR decode, counter and parity checker.

## Test plan
- Reset mid-stream: fill to FULL, assert rst for 1 cycle → in_ready = 1, out_valid = 0, out_a = out_b = 0, word_count = 0.
- Single word: P = 8'hA5, Q = 8'h0F, out_ready = 1 → one cycle later out_a = 8'hA5, out_b = 8'hAA, word_count = 1.
- Back-pressure: out_ready = 0, offer pairs (8'h01,8'h03), (8'h02,8'h02), (8'h04,8'h00) → first two accepted, in_ready = 0 with third pending; release out_ready → outputs in order b = 8'h02, 8'h00, 8'h04.
- Streaming: 100 random back-to-back pairs, out_ready = 1 → 1 output per cycle, every out_b == P^Q, word_count = 100.
- Counter wrap with CNT_W = 4: 17 output handshakes → word_count = 1.
- With FEYNMAN_DEC_PARITY_EN: P = 8'h01, Q = 8'h00, in_par = 0 (bad) → par_err = 1 after accept edge, word still output (a = 8'h01, b = 8'h01); par_err stays 1 through later good words until rst.
